// File: rtl/prog_loader_pkg.sv
// Shared definitions for the programming-mode loader: SAP control-word bit map,
// idle control word, state encodings and small decode helpers.
package prog_loader_pkg;

  localparam int CTRL_W_DEF = 15;

  localparam int SIG_PC_INC          = 14;
  localparam int SIG_PC_EN           = 13;
  localparam int SIG_PC_LOAD         = 12;
  localparam int SIG_MAR_ADDR_LOAD_N = 11;
  localparam int SIG_MAR_MEM_LOAD_N  = 10;
  localparam int SIG_RAM_LOAD_N      = 9;
  localparam int SIG_RAM_OE_N        = 8;
  localparam int SIG_IR_LOAD_N       = 7;
  localparam int SIG_IR_OE_N         = 6;
  localparam int SIG_A_LOAD_N        = 5;
  localparam int SIG_A_OE            = 4;
  localparam int SIG_ALU_OE          = 3;
  localparam int SIG_ALU_SUB         = 2;
  localparam int SIG_B_LOAD_N        = 1;
  localparam int SIG_OUT_LOAD_N      = 0;

  // Every active-low strobe deasserted, every active-high strobe off.
  localparam logic [CTRL_W_DEF-1:0] CTRL_IDLE = 15'b000111111100011;

  typedef enum logic [2:0] {
    PL_IDLE  = 3'd0,
    PL_CLR   = 3'd1,
    PL_WAIT  = 3'd2,
    PL_ADDR  = 3'd3,
    PL_DATA  = 3'd4,
    PL_WRITE = 3'd5,
    PL_INC   = 3'd6,
    PL_DONE  = 3'd7
  } pl_state_e;

  function automatic logic [CTRL_W_DEF-1:0] ctrl_for_state(input pl_state_e s);
    logic [CTRL_W_DEF-1:0] w;
    w = CTRL_IDLE;
    case (s)
      PL_CLR:   w[SIG_PC_LOAD] = 1'b1;
      PL_ADDR: begin
        w[SIG_PC_EN]           = 1'b1;
        w[SIG_MAR_ADDR_LOAD_N] = 1'b0;
      end
      PL_DATA:  w[SIG_MAR_MEM_LOAD_N] = 1'b0;
      PL_WRITE: w[SIG_RAM_LOAD_N]     = 1'b0;
      PL_INC:   w[SIG_PC_INC]         = 1'b1;
      default:  w = CTRL_IDLE;
    endcase
    return w;
  endfunction

  function automatic logic state_drives_bus(input pl_state_e s);
    return (s == PL_CLR) || (s == PL_DATA) || (s == PL_WRITE);
  endfunction

  function automatic logic state_is_busy(input pl_state_e s);
    return (s == PL_ADDR) || (s == PL_DATA) || (s == PL_WRITE) || (s == PL_INC);
  endfunction

endpackage

// File: rtl/prog_loader_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; level is the
// synchronised input, rise is a one-cycle pulse.
module sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/prog_loader.sv
// Programming-mode loader: streams ui_in bytes into SAP RAM at consecutive
// addresses by sequencing the bus and the control word.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int MAX_WORDS = 16,
  parameter int CTRL_W    = CTRL_W_DEF
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [DATA_W-1:0]              ui_in,
  input  logic                           programming,
  input  logic                           new_byte,
  inout  wire  [DATA_W-1:0]              bus,
  output logic [CTRL_W-1:0]              ctrl_out,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] PC_START = '0;

  logic prog_level;
  logic prog_rise;
  logic nb_level;
  logic nb_rise;

  sync_edge u_sync_prog (
    .clk    (clk),
    .resetn (resetn),
    .din    (programming),
    .level  (prog_level),
    .rise   (prog_rise)
  );

  sync_edge u_sync_nb (
    .clk    (clk),
    .resetn (resetn),
    .din    (new_byte),
    .level  (nb_level),
    .rise   (nb_rise)
  );

  pl_state_e          state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    count_d   = count_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    case (state_q)
      PL_IDLE: begin
        if (prog_rise) begin
          state_d   = PL_CLR;
          count_d   = '0;
          done_d    = 1'b0;
          overrun_d = 1'b0;
        end
      end
      PL_CLR:   state_d = PL_WAIT;
      PL_WAIT: begin
        // A simultaneous session end beats a new byte; the byte is dropped silently.
        if (!prog_level) begin
          state_d = PL_IDLE;
        end else if (nb_rise) begin
          data_d  = ui_in;
          state_d = PL_ADDR;
        end
      end
      PL_ADDR:  state_d = PL_DATA;
      PL_DATA:  state_d = PL_WRITE;
      PL_WRITE: state_d = PL_INC;
      PL_INC: begin
        if (count_q != MAX_CNT) begin
          count_d = count_q + CNT_W'(1);
        end
        if (count_d == MAX_CNT) begin
          state_d = PL_DONE;
          done_d  = 1'b1;
        end else if (!prog_level) begin
          state_d = PL_IDLE;
        end else begin
          state_d = PL_WAIT;
        end
      end
      PL_DONE: begin
        if (!prog_level) begin
          state_d = PL_IDLE;
          done_d  = 1'b0;
        end
      end
      default:  state_d = PL_IDLE;
    endcase
    if (nb_rise && (state_is_busy(state_q) || (state_q == PL_DONE))) begin
      overrun_d = 1'b1;
    end
    busy_d = state_is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= PL_IDLE;
      data_q    <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      count_q   <= count_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  // Control word and bus drive change half a cycle after the state so that
  // consumers see a settled word at the next rising edge.
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              bus_oe_q, bus_oe_d;
  logic [DATA_W-1:0] bus_val_q, bus_val_d;

  always_comb begin
    ctrl_d    = CTRL_W'(CTRL_IDLE);
    bus_oe_d  = 1'b0;
    bus_val_d = '0;
    if (resetn) begin
      ctrl_d    = CTRL_W'(ctrl_for_state(state_q));
      bus_oe_d  = state_drives_bus(state_q);
      bus_val_d = (state_q == PL_CLR) ? DATA_W'(PC_START) : data_q;
    end
  end

  always_ff @(negedge clk) begin
    ctrl_q    <= ctrl_d;
    bus_oe_q  <= bus_oe_d;
    bus_val_q <= bus_val_d;
  end

  assign bus        = bus_oe_q ? bus_val_q : {DATA_W{1'bz}};
  assign ctrl_out   = ctrl_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;
  assign word_count = count_q;

  logic unused_ok;
  assign unused_ok = nb_level;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a behavioural SAP model (PC, MAR, data
// latch, RAM) driven by ctrl_out/bus, with a write scoreboard and vector table.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        programming = 1'b0;
  logic        new_byte = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  wire  [7:0]  bus;
  logic [14:0] ctrl_out;
  logic        busy, done, overrun;
  logic [4:0]  word_count;

  prog_loader #(.DATA_W(8), .ADDR_W(4), .MAX_WORDS(16), .CTRL_W(15)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ui_in       (ui_in),
    .programming (programming),
    .new_byte    (new_byte),
    .bus         (bus),
    .ctrl_out    (ctrl_out),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .word_count  (word_count)
  );

  // Released bus reads as all ones, so 8'hFF stands for 'z here.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (bus[gi]);
  end

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // SAP consumer model, clocked on the rising edge like the real datapath
  logic        mon_en = 1'b0;
  logic [3:0]  pc_m, mar_m;
  logic [7:0]  mdr_m;
  logic [7:0]  ram_m [16];
  logic [14:0] prev1 = CTRL_IDLE, prev2 = CTRL_IDLE;
  logic        inc_pend = 1'b0;
  int          obs_n = 0;
  logic [3:0]  obs_addr [512];
  logic [7:0]  obs_data [512];
  logic        obs_seq  [512];
  logic        obs_inc  [512];

  always @(posedge clk) begin
    if (mon_en) begin
      if (inc_pend) begin
        obs_inc[obs_n-1] <= ctrl_out[SIG_PC_INC];
        inc_pend <= 1'b0;
      end
      if (ctrl_out[SIG_PC_LOAD]) pc_m <= bus[3:0];
      else if (ctrl_out[SIG_PC_INC]) pc_m <= pc_m + 4'd1;
      if (!ctrl_out[SIG_MAR_ADDR_LOAD_N] && ctrl_out[SIG_PC_EN]) mar_m <= pc_m;
      if (!ctrl_out[SIG_MAR_MEM_LOAD_N]) mdr_m <= bus;
      if (!ctrl_out[SIG_RAM_LOAD_N]) begin
        ram_m[mar_m]    <= mdr_m;
        obs_addr[obs_n] <= mar_m;
        obs_data[obs_n] <= mdr_m;
        obs_seq[obs_n]  <= !prev1[SIG_MAR_MEM_LOAD_N] && !prev2[SIG_MAR_ADDR_LOAD_N]
                           && prev2[SIG_PC_EN];
        obs_n    <= obs_n + 1;
        inc_pend <= 1'b1;
      end
      prev2 <= prev1;
      prev1 <= ctrl_out;
    end
  end

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];
  int  rd = 0;
  int  exp_addr = 0;

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    logic       exp_done;
    logic       exp_ovr;
  } vec_t;
  vec_t vecs[3];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d);
    wr_t e;
    e.addr = exp_addr[3:0];
    e.data = d;
    exp_q.push_back(e);
    exp_addr++;
  endtask

  task automatic send_byte(input logic [7:0] d);
    ui_in    = d;
    new_byte = 1'b1;
    cyc(4);
    new_byte = 1'b0;
    cyc(6);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      cyc(1);
      n++;
    end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_writes();
    wr_t e;
    while (rd < obs_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                 obs_addr[rd], obs_data[rd]);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {28'd0, obs_addr[rd]}, {28'd0, e.addr});
        chk("wr_data", {24'd0, obs_data[rd]}, {24'd0, e.data});
        chk("wr_ctrl_seq", {31'd0, obs_seq[rd]}, 32'd1);
        chk("wr_pc_inc", {31'd0, obs_inc[rd]}, 32'd1);
        $display("txn write addr=%0h data=%02h", obs_addr[rd], obs_data[rd]);
      end
      rd++;
    end
    chk("missing_writes", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic start_session();
    programming = 1'b0;
    cyc(4);
    programming = 1'b1;
    cyc(6);
    exp_addr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h3A, 1, 1'b0, 1'b0};
    vecs[1] = '{8'h5C, 2, 1'b0, 1'b0};
    vecs[2] = '{8'h7F, 3, 1'b0, 1'b0};

    // Reset held for two rising edges
    resetn = 1'b0;
    cyc(2);
    chk("rst_ctrl", {17'd0, ctrl_out}, 32'h0FE3);
    chk("rst_bus", {24'd0, bus}, 32'hFF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_count", {27'd0, word_count}, 32'd0);
    resetn = 1'b1;
    mon_en = 1'b1;
    cyc(2);

    // Three bytes, table driven
    start_session();
    for (int i = 0; i < 3; i++) begin
      push_exp(vecs[i].data);
      send_byte(vecs[i].data);
      wait_idle();
      chk("t2_count", {27'd0, word_count}, vecs[i].exp_count);
      chk("t2_done", {31'd0, done}, {31'd0, vecs[i].exp_done});
      chk("t2_overrun", {31'd0, overrun}, {31'd0, vecs[i].exp_ovr});
      check_writes();
    end
    chk("t2_ram0", {24'd0, ram_m[0]}, 32'h3A);
    chk("t2_ram2", {24'd0, ram_m[2]}, 32'h7F);

    // Fill all 16 words, then one byte too many
    start_session();
    for (int i = 0; i < 16; i++) begin
      push_exp(i[7:0]);
      send_byte(i[7:0]);
    end
    wait_idle();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_overrun_pre", {31'd0, overrun}, 32'd0);
    chk("t3_count", {27'd0, word_count}, 32'd16);
    check_writes();
    send_byte(8'hAA);
    cyc(4);
    chk("t3_overrun", {31'd0, overrun}, 32'd1);
    chk("t3_done_sticky", {31'd0, done}, 32'd1);
    chk("t3_count_sat", {27'd0, word_count}, 32'd16);
    chk("t3_ram15", {24'd0, ram_m[15]}, 32'h0F);
    check_writes();

    // Second new_byte edge while the first byte is in flight
    start_session();
    push_exp(8'h11);
    ui_in    = 8'h11;
    new_byte = 1'b1;
    cyc(2);
    new_byte = 1'b0;
    cyc(1);
    ui_in    = 8'h99;
    new_byte = 1'b1;
    cyc(3);
    new_byte = 1'b0;
    cyc(8);
    wait_idle();
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    chk("t4_count", {27'd0, word_count}, 32'd1);
    check_writes();

    // Programming falls while the byte is in DATA
    start_session();
    push_exp(8'h22);
    ui_in    = 8'h22;
    new_byte = 1'b1;
    cyc(4);
    programming = 1'b0;
    new_byte    = 1'b0;
    cyc(3);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_bus", {24'd0, bus}, 32'hFF);
    chk("t5_count", {27'd0, word_count}, 32'd1);
    cyc(4);
    check_writes();
    send_byte(8'h44);
    cyc(4);
    chk("t5_idle_count", {27'd0, word_count}, 32'd1);
    check_writes();

    // new_byte and programming fall together in WAIT: byte dropped, no overrun
    start_session();
    ui_in       = 8'h55;
    new_byte    = 1'b1;
    programming = 1'b0;
    cyc(4);
    new_byte = 1'b0;
    cyc(6);
    chk("t5b_overrun", {31'd0, overrun}, 32'd0);
    chk("t5b_count", {27'd0, word_count}, 32'd0);
    chk("t5b_busy", {31'd0, busy}, 32'd0);
    check_writes();

    // Reset asserted while in WRITE
    start_session();
    ui_in    = 8'h33;
    new_byte = 1'b1;
    cyc(4);
    new_byte = 1'b0;
    cyc(1);
    chk("t6_in_write", {31'd0, ctrl_out[SIG_RAM_LOAD_N]}, 32'd0);
    resetn = 1'b0;
    cyc(1);
    chk("t6_ram_load_n", {31'd0, ctrl_out[SIG_RAM_LOAD_N]}, 32'd1);
    chk("t6_ctrl", {17'd0, ctrl_out}, 32'h0FE3);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_count", {27'd0, word_count}, 32'd0);
    cyc(1);
    resetn      = 1'b1;
    programming = 1'b0;
    cyc(4);
    chk("t6_bus", {24'd0, bus}, 32'hFF);
    rd = obs_n;
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
